id_ex_pipe: RTL and testbench
=============================

Name: id_ex_pipe

Overview:
Parametrised ID/EX pipeline stage for the five-stage MIPS core. Registers decoded operands and control from the RFile/MainControl decode path into the execute stage. Adds valid tagging, downstream hold, branch flush, load-use hazard detection with single-bubble insertion, EX-operand forwarding selects and a bubble counter. Sits between decode and ExecUnit.

Parameters:
DATA_W  32  operand/PC width
REG_AW  5  register address width
IMM_W  16  immediate width
CNT_W  16  bubble counter width

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
id_valid  in  1  decode slot holds a real instruction
id_pc  in  DATA_W  PC of decode instruction
id_rs  in  REG_AW  rs field
id_rt  in  REG_AW  rt field
id_rd  in  REG_AW  rd field
id_imm  in  IMM_W  immediate field
id_busa  in  DATA_W  RFile port A data
id_busb  in  DATA_W  RFile port B data
id_ctrl  in  11  {ExtOp,ALUSrc,ALUop[2:0],RegDst,R_type,MemWr,Branch,MemtoReg,RegWr}, bit10..bit0
ex_hold  in  1  downstream stall; EX must keep contents
flush  in  1  branch taken; kill incoming instruction
mem_rw  in  REG_AW  EX/MEM destination register
mem_regwr  in  1  EX/MEM writes register
wb_rw  in  REG_AW  MEM/WB destination register
wb_regwr  in  1  MEM/WB writes register
id_stall  out  1  freeze PC and IF/ID
ex_valid  out  1  EX slot holds a real instruction
ex_pc  out  DATA_W  registered PC
ex_rs, ex_rt, ex_rd  out  REG_AW  registered register fields
ex_imm  out  IMM_W  registered immediate
ex_busa, ex_busb  out  DATA_W  registered operands
ex_ctrl  out  11  registered control, same bit order
ex_rw  out  REG_AW  EX destination register
fwd_a, fwd_b  out  2  operand A/B source: 00 register, 01 EX/MEM, 10 MEM/WB
bubble_cnt  out  CNT_W  inserted bubble count

Behaviour:
- Reset (async, immediate, also mid-operation): every ex_* register, ex_valid and bubble_cnt = 0; outputs therefore ex_rw=0, fwd_a=fwd_b=00, id_stall=0 once reset is released with no hazard.
- Latency: one cycle, ID inputs to ex_* outputs.
- load_use (comb) = ex_valid & ex_ctrl[1] & ex_ctrl[0] & id_valid & ex_rw!=0 & (ex_rw==id_rs | ex_rw==id_rt).
- id_stall (comb) = ex_hold | load_use. flush does not drive id_stall.
- Per-edge priority, highest first:
  1. flush: ex_valid<=0, ex_ctrl<=0, data fields load ID values; applies even when ex_hold=1.
  2. ex_hold: all EX registers hold.
  3. load_use: bubble; ex_valid<=0, ex_ctrl<=0, data fields hold.
  4. normal: all fields load ID inputs; ex_valid<=id_valid; ex_ctrl<=id_valid ? id_ctrl : 0.
- A bubble leaves ex_valid=0, so load_use deasserts the next cycle. Exactly one bubble per load-use pair.
- bubble_cnt increments by 1 on each edge taking case 1 or 3. It saturates at all-ones with no wrap.
- ex_rw (comb) = !ex_valid ? 0 : (ex_ctrl[5] ? ex_rd : ex_rt).
- fwd_a (comb) selects in priority order:
  - 01 if ex_valid & mem_regwr & mem_rw!=0 & mem_rw==ex_rs;
  - else 10 if ex_valid & wb_regwr & wb_rw!=0 & wb_rw==ex_rs;
  - else 00.
  - EX/MEM wins when both match.
- fwd_b: same rule using ex_rt.
- Register 0 never forwards and never triggers load_use.
- Widths: no arithmetic on data; fields pass bit-exact. Immediate extension remains in ExecUnit.

Test Plan:
- Reset during valid EX (ex_valid=1, ex_pc=0x40): assert reset mid-cycle -> all outputs 0 before next edge; bubble_cnt=0.
- Normal flow: id_valid=1, id_pc=0x100, id_ctrl=11'h021 (RegDst,RegWr), rd=5 -> next edge ex_pc=0x100, ex_valid=1, ex_rw=5, id_stall=0.
- Load-use: EX lw (ctrl bits1,0 set, RegDst=0, rt=8), ID rs=8 -> id_stall=1; next edge ex_valid=0, ex_ctrl=0, bubble_cnt=1; following edge instruction enters, id_stall=0.
- Flush with hold: flush=1, ex_hold=1 -> next edge ex_valid=0, bubble_cnt +1. Hold alone for 3 cycles -> ex_* unchanged and id_stall=1.
- Forwarding: ex_rs=ex_rt=9, mem_rw=9/mem_regwr=1, wb_rw=9/wb_regwr=1 -> fwd_a=fwd_b=01. Drop mem_regwr -> 10. Register index 0 on all -> 00.
- Saturation: CNT_W=2, 5 flushes -> bubble_cnt=3.

Source files
------------

// File: rtl/id_ex_pipe.sv
// ============================================================================
// id_ex_pipe
// ----------------------------------------------------------------------------
// ID/EX pipeline register for the five-stage MIPS core. Captures the decoded
// operands, register fields, immediate and control word coming out of the
// RFile/MainControl decode path and presents them to ExecUnit one cycle later.
//
// On top of the plain register it provides:
//   - a valid tag that travels with the instruction,
//   - a downstream hold (ex_hold) that freezes the EX slot,
//   - a branch flush that kills the incoming instruction,
//   - load-use hazard detection that inserts exactly one bubble,
//   - EX operand forwarding selects (EX/MEM over MEM/WB),
//   - a saturating count of inserted bubbles.
//
// Ports
//   clk, reset          rising-edge clock, asynchronous active-high reset
//   id_valid            decode slot holds a real instruction
//   id_pc               PC of the decode instruction
//   id_rs/id_rt/id_rd   register fields from decode
//   id_imm              raw immediate (extension happens in ExecUnit)
//   id_busa/id_busb     RFile read data
//   id_ctrl             {ExtOp,ALUSrc,ALUop[2:0],RegDst,R_type,MemWr,
//                        Branch,MemtoReg,RegWr}, bit10..bit0
//   ex_hold             downstream stall, EX keeps its contents
//   flush               branch taken, incoming instruction is killed
//   mem_rw/mem_regwr    EX/MEM destination register and write enable
//   wb_rw/wb_regwr      MEM/WB destination register and write enable
//   id_stall            freeze PC and IF/ID
//   ex_*                registered copies of the decode fields
//   ex_rw               destination register of the EX instruction
//   fwd_a/fwd_b         operand source: 00 register, 01 EX/MEM, 10 MEM/WB
//   bubble_cnt          number of bubbles inserted (flush or load-use)
// ============================================================================
module id_ex_pipe #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5,
    parameter int IMM_W  = 16,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [DATA_W-1:0] id_pc,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic [REG_AW-1:0] id_rd,
    input  logic [IMM_W-1:0]  id_imm,
    input  logic [DATA_W-1:0] id_busa,
    input  logic [DATA_W-1:0] id_busb,
    input  logic [10:0]       id_ctrl,
    input  logic              ex_hold,
    input  logic              flush,
    input  logic [REG_AW-1:0] mem_rw,
    input  logic              mem_regwr,
    input  logic [REG_AW-1:0] wb_rw,
    input  logic              wb_regwr,
    output logic              id_stall,
    output logic              ex_valid,
    output logic [DATA_W-1:0] ex_pc,
    output logic [REG_AW-1:0] ex_rs,
    output logic [REG_AW-1:0] ex_rt,
    output logic [REG_AW-1:0] ex_rd,
    output logic [IMM_W-1:0]  ex_imm,
    output logic [DATA_W-1:0] ex_busa,
    output logic [DATA_W-1:0] ex_busb,
    output logic [10:0]       ex_ctrl,
    output logic [REG_AW-1:0] ex_rw,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic [CNT_W-1:0]  bubble_cnt
);

    // Control word bit positions used locally.
    localparam int CTRL_REGDST   = 5;
    localparam int CTRL_MEMTOREG = 1;
    localparam int CTRL_REGWR    = 0;

    // Forwarding select encodings.
    localparam logic [1:0] FWD_REG   = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b01;
    localparam logic [1:0] FWD_MEMWB = 2'b10;

    // ------------------------------------------------------------------------
    // EX slot state
    // ------------------------------------------------------------------------
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] pc_q,    pc_d;
    logic [REG_AW-1:0] rs_q,    rs_d;
    logic [REG_AW-1:0] rt_q,    rt_d;
    logic [REG_AW-1:0] rd_q,    rd_d;
    logic [IMM_W-1:0]  imm_q,   imm_d;
    logic [DATA_W-1:0] busa_q,  busa_d;
    logic [DATA_W-1:0] busb_q,  busb_d;
    logic [10:0]       ctrl_q,  ctrl_d;
    logic [CNT_W-1:0]  cnt_q,   cnt_d;

    logic              load_use;
    logic              take_data;
    logic              kill_slot;

    // ------------------------------------------------------------------------
    // Destination register of the EX instruction. An empty slot reports r0 so
    // it can never look like a producer to the hazard/forwarding logic.
    // ------------------------------------------------------------------------
    always_comb begin
        if (!valid_q) begin
            ex_rw = '0;
        end else if (ctrl_q[CTRL_REGDST]) begin
            ex_rw = rd_q;
        end else begin
            ex_rw = rt_q;
        end
    end

    // ------------------------------------------------------------------------
    // Load-use hazard: a load in EX (MemtoReg and RegWr) whose destination is
    // a source of the decode instruction. r0 is excluded since it is never
    // actually written.
    // ------------------------------------------------------------------------
    always_comb begin
        load_use = valid_q & ctrl_q[CTRL_MEMTOREG] & ctrl_q[CTRL_REGWR] &
                   id_valid & (ex_rw != '0) &
                   ((ex_rw == id_rs) | (ex_rw == id_rt));
    end

    // Decode must freeze while EX is held or while the bubble is inserted.
    // A flush replaces the incoming instruction, so it does not stall decode.
    assign id_stall = ex_hold | load_use;

    // ------------------------------------------------------------------------
    // Edge action decode. Flush outranks hold (a taken branch must kill the
    // incoming instruction even while EX is frozen); hold outranks the
    // load-use bubble (a held slot cannot accept a bubble either).
    //   take_data : data fields load from decode
    //   kill_slot : valid and control cleared, counted as a bubble
    // ------------------------------------------------------------------------
    always_comb begin
        take_data = flush | (~ex_hold & ~load_use);
        kill_slot = flush | (~ex_hold & load_use);
    end

    // ------------------------------------------------------------------------
    // Next-state for the EX slot. Defaults hold every field; take_data and
    // kill_slot then override the data and the valid/control parts
    // independently, which covers all four edge cases.
    // ------------------------------------------------------------------------
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        busa_d  = busa_q;
        busb_d  = busb_q;
        ctrl_d  = ctrl_q;
        cnt_d   = cnt_q;

        if (take_data) begin
            pc_d   = id_pc;
            rs_d   = id_rs;
            rt_d   = id_rt;
            rd_d   = id_rd;
            imm_d  = id_imm;
            busa_d = id_busa;
            busb_d = id_busb;
        end

        if (kill_slot) begin
            valid_d = 1'b0;
            ctrl_d  = '0;
            // Saturate rather than wrap so a long run never reads as few bubbles.
            if (!(&cnt_q)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (!ex_hold) begin
            valid_d = id_valid;
            ctrl_d  = id_valid ? id_ctrl : '0;
        end
    end

    // ------------------------------------------------------------------------
    // EX slot registers with asynchronous clear.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            rs_q    <= '0;
            rt_q    <= '0;
            rd_q    <= '0;
            imm_q   <= '0;
            busa_q  <= '0;
            busb_q  <= '0;
            ctrl_q  <= '0;
            cnt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            busa_q  <= busa_d;
            busb_q  <= busb_d;
            ctrl_q  <= ctrl_d;
            cnt_q   <= cnt_d;
        end
    end

    // ------------------------------------------------------------------------
    // Forwarding selects. The EX/MEM result is younger than MEM/WB, so it wins
    // when both stages write the same register. r0 is never forwarded.
    // ------------------------------------------------------------------------
    always_comb begin
        fwd_a = FWD_REG;
        if (valid_q & mem_regwr & (mem_rw != '0) & (mem_rw == rs_q)) begin
            fwd_a = FWD_EXMEM;
        end else if (valid_q & wb_regwr & (wb_rw != '0) & (wb_rw == rs_q)) begin
            fwd_a = FWD_MEMWB;
        end
    end

    always_comb begin
        fwd_b = FWD_REG;
        if (valid_q & mem_regwr & (mem_rw != '0) & (mem_rw == rt_q)) begin
            fwd_b = FWD_EXMEM;
        end else if (valid_q & wb_regwr & (wb_rw != '0) & (wb_rw == rt_q)) begin
            fwd_b = FWD_MEMWB;
        end
    end

    // Registered outputs.
    assign ex_valid   = valid_q;
    assign ex_pc      = pc_q;
    assign ex_rs      = rs_q;
    assign ex_rt      = rt_q;
    assign ex_rd      = rd_q;
    assign ex_imm     = imm_q;
    assign ex_busa    = busa_q;
    assign ex_busb    = busb_q;
    assign ex_ctrl    = ctrl_q;
    assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_id_ex_pipe.sv
// ============================================================================
// tb_id_ex_pipe
// ----------------------------------------------------------------------------
// Self-checking bench for id_ex_pipe. Two instances share all inputs: the
// default one and one with a 2-bit bubble counter for saturation. A
// behavioural model of the EX slot is compared against the DUTs on every
// falling edge; directed literal checks pin the model to known values.
// ============================================================================
module tb_id_ex_pipe;

    logic        clk;
    logic        reset;
    logic        id_valid;
    logic [31:0] id_pc;
    logic [4:0]  id_rs, id_rt, id_rd;
    logic [15:0] id_imm;
    logic [31:0] id_busa, id_busb;
    logic [10:0] id_ctrl;
    logic        ex_hold, flush;
    logic [4:0]  mem_rw, wb_rw;
    logic        mem_regwr, wb_regwr;

    logic        id_stall, ex_valid;
    logic [31:0] ex_pc, ex_busa, ex_busb;
    logic [4:0]  ex_rs, ex_rt, ex_rd, ex_rw;
    logic [15:0] ex_imm;
    logic [10:0] ex_ctrl;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] bubble_cnt;

    logic        s_id_stall, s_ex_valid;
    logic [31:0] s_ex_pc, s_ex_busa, s_ex_busb;
    logic [4:0]  s_ex_rs, s_ex_rt, s_ex_rd, s_ex_rw;
    logic [15:0] s_ex_imm;
    logic [10:0] s_ex_ctrl;
    logic [1:0]  s_fwd_a, s_fwd_b;
    logic [1:0]  s_bubble_cnt;

    int compared   = 0;
    int mismatched = 0;
    bit checkEn    = 0;

    id_ex_pipe dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
        .id_busa(id_busa), .id_busb(id_busb), .id_ctrl(id_ctrl),
        .ex_hold(ex_hold), .flush(flush), .mem_rw(mem_rw),
        .mem_regwr(mem_regwr), .wb_rw(wb_rw), .wb_regwr(wb_regwr),
        .id_stall(id_stall), .ex_valid(ex_valid), .ex_pc(ex_pc),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd), .ex_imm(ex_imm),
        .ex_busa(ex_busa), .ex_busb(ex_busb), .ex_ctrl(ex_ctrl),
        .ex_rw(ex_rw), .fwd_a(fwd_a), .fwd_b(fwd_b), .bubble_cnt(bubble_cnt)
    );

    id_ex_pipe #(.CNT_W(2)) dutSmall (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_pc(id_pc),
        .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_imm(id_imm),
        .id_busa(id_busa), .id_busb(id_busb), .id_ctrl(id_ctrl),
        .ex_hold(ex_hold), .flush(flush), .mem_rw(mem_rw),
        .mem_regwr(mem_regwr), .wb_rw(wb_rw), .wb_regwr(wb_regwr),
        .id_stall(s_id_stall), .ex_valid(s_ex_valid), .ex_pc(s_ex_pc),
        .ex_rs(s_ex_rs), .ex_rt(s_ex_rt), .ex_rd(s_ex_rd), .ex_imm(s_ex_imm),
        .ex_busa(s_ex_busa), .ex_busb(s_ex_busb), .ex_ctrl(s_ex_ctrl),
        .ex_rw(s_ex_rw), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
        .bubble_cnt(s_bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // Model of what the EX slot holds: the instruction, and how many bubbles
    // have been inserted so far.
    // ------------------------------------------------------------------------
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rs, rt, rd;
        logic [15:0] imm;
        logic [31:0] busa, busb;
        logic [10:0] ctrl;
        logic [31:0] bubbles;
    } slot_t;

    slot_t m;

    function automatic logic [4:0] destOf(slot_t s);
        if (!s.valid) return 5'd0;
        return s.ctrl[5] ? s.rd : s.rt;
    endfunction

    function automatic logic isLoadUse(slot_t s);
        logic [4:0] d = destOf(s);
        return s.valid && s.ctrl[1] && s.ctrl[0] && id_valid && d != 0 &&
               (d == id_rs || d == id_rt);
    endfunction

    function automatic logic [1:0] srcOf(slot_t s, logic [4:0] r);
        if (s.valid && mem_regwr && mem_rw != 0 && mem_rw == r) return 2'b01;
        if (s.valid && wb_regwr && wb_rw != 0 && wb_rw == r) return 2'b10;
        return 2'b00;
    endfunction

    function automatic slot_t captureId(slot_t s);
        slot_t n = s;
        n.pc = id_pc; n.rs = id_rs; n.rt = id_rt; n.rd = id_rd;
        n.imm = id_imm; n.busa = id_busa; n.busb = id_busb;
        return n;
    endfunction

    function automatic slot_t nextSlot(slot_t s);
        slot_t n = s;
        if (flush) begin
            n = captureId(s);
            n.valid = 0; n.ctrl = 0;
            if (n.bubbles < 32'd65535) n.bubbles = n.bubbles + 1;
        end else if (ex_hold) begin
            n = s;
        end else if (isLoadUse(s)) begin
            n.valid = 0; n.ctrl = 0;
            if (n.bubbles < 32'd65535) n.bubbles = n.bubbles + 1;
        end else begin
            n = captureId(s);
            n.valid = id_valid;
            n.ctrl  = id_valid ? id_ctrl : 11'd0;
        end
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= nextSlot(m);
    end

    task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison of both DUTs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            checkOutput("m.ex_valid",   ex_valid,   m.valid);
            checkOutput("m.ex_pc",      ex_pc,      m.pc);
            checkOutput("m.ex_rs",      ex_rs,      m.rs);
            checkOutput("m.ex_rt",      ex_rt,      m.rt);
            checkOutput("m.ex_rd",      ex_rd,      m.rd);
            checkOutput("m.ex_imm",     ex_imm,     m.imm);
            checkOutput("m.ex_busa",    ex_busa,    m.busa);
            checkOutput("m.ex_busb",    ex_busb,    m.busb);
            checkOutput("m.ex_ctrl",    ex_ctrl,    m.ctrl);
            checkOutput("m.ex_rw",      ex_rw,      destOf(m));
            checkOutput("m.fwd_a",      fwd_a,      srcOf(m, m.rs));
            checkOutput("m.fwd_b",      fwd_b,      srcOf(m, m.rt));
            checkOutput("m.id_stall",   id_stall,   ex_hold | isLoadUse(m));
            checkOutput("m.bubble_cnt", bubble_cnt, m.bubbles);
            checkOutput("m.small_cnt",  s_bubble_cnt, (m.bubbles > 3) ? 3 : m.bubbles);
            checkOutput("m.small_pc",   s_ex_pc,    m.pc);
        end
    end

    // One clock edge; returns just after the edge with outputs settled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(logic v, logic [31:0] pc, logic [4:0] rs,
                                 logic [4:0] rt, logic [4:0] rd, logic [10:0] ctrl);
        id_valid = v; id_pc = pc; id_rs = rs; id_rt = rt; id_rd = rd;
        id_ctrl = ctrl;
        id_imm  = pc[15:0] ^ 16'h5a5a;
        id_busa = pc ^ 32'hdead0000;
        id_busb = pc ^ 32'h0000beef;
    endtask

    initial begin
        reset = 1; flush = 0; ex_hold = 0;
        mem_rw = 0; mem_regwr = 0; wb_rw = 0; wb_regwr = 0;
        applyStimulus(0, 0, 0, 0, 0, 0);
        step(); step();
        reset = 0;
        checkEn = 1;

        // Reset state.
        checkOutput("rst.ex_valid", ex_valid, 0);
        checkOutput("rst.bubble_cnt", bubble_cnt, 0);
        checkOutput("rst.id_stall", id_stall, 0);

        // Normal flow: R-type writing rd=5.
        applyStimulus(1, 32'h100, 1, 2, 5, 11'h021);
        step();
        checkOutput("norm.ex_pc", ex_pc, 32'h100);
        checkOutput("norm.ex_valid", ex_valid, 1);
        checkOutput("norm.ex_rw", ex_rw, 5);
        checkOutput("norm.id_stall", id_stall, 0);

        // Load-use: lw to rt=8 followed by a reader of r8.
        applyStimulus(1, 32'h104, 0, 8, 0, 11'h603);
        step();
        checkOutput("lu.ex_rw", ex_rw, 8);
        applyStimulus(1, 32'h108, 8, 3, 4, 11'h021);
        #1;
        checkOutput("lu.id_stall", id_stall, 1);
        step();
        checkOutput("lu.bub_valid", ex_valid, 0);
        checkOutput("lu.bub_ctrl", ex_ctrl, 0);
        checkOutput("lu.bub_cnt", bubble_cnt, 1);
        checkOutput("lu.bub_pc", ex_pc, 32'h104);
        checkOutput("lu.stall_clear", id_stall, 0);
        step();
        checkOutput("lu.enter_pc", ex_pc, 32'h108);
        checkOutput("lu.enter_valid", ex_valid, 1);

        // Flush together with hold.
        applyStimulus(1, 32'h10c, 1, 1, 1, 11'h021);
        flush = 1; ex_hold = 1;
        step();
        flush = 0; ex_hold = 0;
        checkOutput("fl.ex_valid", ex_valid, 0);
        checkOutput("fl.bubble_cnt", bubble_cnt, 2);
        checkOutput("fl.ex_pc", ex_pc, 32'h10c);

        // Hold alone for three cycles over a valid instruction.
        applyStimulus(1, 32'h110, 9, 9, 7, 11'h021);
        step();
        ex_hold = 1;
        applyStimulus(1, 32'h200, 2, 3, 4, 11'h021);
        for (int i = 0; i < 3; i++) begin
            step();
            checkOutput("hold.ex_pc", ex_pc, 32'h110);
            checkOutput("hold.id_stall", id_stall, 1);
        end

        // Forwarding with ex_rs = ex_rt = 9.
        mem_rw = 9; mem_regwr = 1; wb_rw = 9; wb_regwr = 1;
        #1;
        checkOutput("fwd.a_mem", fwd_a, 2'b01);
        checkOutput("fwd.b_mem", fwd_b, 2'b01);
        mem_regwr = 0;
        #1;
        checkOutput("fwd.a_wb", fwd_a, 2'b10);
        checkOutput("fwd.b_wb", fwd_b, 2'b10);
        ex_hold = 0;
        applyStimulus(1, 32'h204, 0, 0, 6, 11'h021);
        step();
        mem_rw = 0; mem_regwr = 1; wb_rw = 0; wb_regwr = 1;
        #1;
        checkOutput("fwd.a_r0", fwd_a, 2'b00);
        checkOutput("fwd.b_r0", fwd_b, 2'b00);

        // Mixed traffic with small register indices to provoke hazards.
        for (int i = 0; i < 80; i++) begin
            applyStimulus($urandom_range(0, 3) != 0, $urandom, 5'($urandom_range(0, 3)),
                          5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                          11'($urandom));
            if ($urandom_range(0, 3) == 0) id_ctrl[1:0] = 2'b11;
            flush     = ($urandom_range(0, 7) == 0);
            ex_hold   = ($urandom_range(0, 4) == 0);
            mem_rw    = 5'($urandom_range(0, 3));
            mem_regwr = 1'($urandom_range(0, 1));
            wb_rw     = 5'($urandom_range(0, 3));
            wb_regwr  = 1'($urandom_range(0, 1));
            step();
        end
        flush = 0; ex_hold = 0;

        // Asynchronous reset while EX holds a valid instruction.
        applyStimulus(1, 32'h40, 0, 0, 3, 11'h021);
        mem_rw = 3; mem_regwr = 1; wb_rw = 0; wb_regwr = 0;
        step();
        checkOutput("arst.pre_pc", ex_pc, 32'h40);
        checkOutput("arst.pre_valid", ex_valid, 1);
        #2;
        reset = 1;
        #1;
        checkOutput("arst.ex_valid", ex_valid, 0);
        checkOutput("arst.ex_pc", ex_pc, 0);
        checkOutput("arst.ex_rw", ex_rw, 0);
        checkOutput("arst.bubble_cnt", bubble_cnt, 0);
        checkOutput("arst.fwd_a", fwd_a, 0);
        step();
        reset = 0;

        // Saturation of the 2-bit counter after five flushes.
        flush = 1;
        for (int i = 0; i < 5; i++) step();
        flush = 0;
        checkOutput("sat.small_cnt", s_bubble_cnt, 2'd3);
        checkOutput("sat.wide_cnt", bubble_cnt, 16'd5);
        step();

        checkEn = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
